// File: rtl/func_inc_arbiter_if.sv
// Request/result bundle for func_inc_arbiter: NUM_REQ valid/ready request ports
// plus the single tagged result port and the increment counter.
interface func_inc_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_enable;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_wrap;
  logic [15:0]               inc_count;

  modport master (
    output req_valid, req_data, req_enable, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_wrap, inc_count
  );

  modport slave (
    input  req_valid, req_data, req_enable, out_ready,
    output req_ready, out_valid, out_data, out_id, out_wrap, inc_count
  );
endinterface

// File: rtl/func_inc_arbiter.sv
// Round-robin arbiter sharing one increment-or-pass datapath among NUM_REQ
// requesters; the result is registered and tagged with the winning index.
module func_inc_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
) (
  input logic             clk,
  input logic             rst,
  func_inc_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   ptr, ptr_next, grant;
  logic [ID_W:0]     scan_idx;
  logic              found, slot_open, transfer;
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [DATA_W-1:0] sel_data, out_data_r;
  logic              sel_en, out_wrap_r;
  logic [ID_W-1:0]   out_id_r;
  logic [15:0]       inc_count_r;
  logic [NUM_REQ-1:0] ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ))
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = scan_idx[ID_W-1:0];
      end
    end
  end

  assign slot_open = (state == EMPTY) || bus.out_ready;
  assign transfer  = found && slot_open && !rst;
  assign sel_data  = data_arr[grant];
  assign sel_en    = bus.req_enable[grant];
  assign ptr_next  = (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;

  always_comb begin
    ready = '0;
    if (transfer)
      ready[grant] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (transfer) state_next = FULL;
      FULL:  if (!transfer && bus.out_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Result fields only move on a transfer, so they hold through drain and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      ptr         <= '0;
      out_data_r  <= '0;
      out_id_r    <= '0;
      out_wrap_r  <= 1'b0;
      inc_count_r <= '0;
    end else begin
      state <= state_next;
      if (transfer) begin
        out_data_r <= sel_en ? sel_data + 1'b1 : sel_data;
        out_wrap_r <= sel_en && (sel_data == {DATA_W{1'b1}});
        out_id_r   <= grant;
        ptr        <= ptr_next;
        if (sel_en)
          inc_count_r <= inc_count_r + 16'd1;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = out_data_r;
  assign bus.out_id    = out_id_r;
  assign bus.out_wrap  = out_wrap_r;
  assign bus.inc_count = inc_count_r;
endmodule

// File: tb/tb_func_inc_arbiter.sv
// Self-checking bench for func_inc_arbiter: a vector table with hand-derived
// grants, a result scoreboard, and a short random-backpressure fairness run.
module tb_func_inc_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [63:0] data;
    logic [3:0]  en;
    logic        oready;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  id;
    logic        wrap;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  func_inc_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  func_inc_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  vec_t  vecs[$];
  res_t  sb[$];
  res_t  last;
  logic  mv;
  logic [15:0] count_m;
  int checks = 0;
  int passed = 0;

  localparam logic [63:0] RR_DATA = {16'h0D00, 16'h0C00, 16'h0B00, 16'h0A00};

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  task automatic addVec(input logic r, input logic [3:0] v, input logic [63:0] d,
                        input logic [3:0] e, input logic o, input logic [3:0] x);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.en = e; t.oready = o; t.exp_ready = x;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input vec_t t);
    rst            = t.rst;
    bus.req_valid  = t.valid;
    bus.req_data   = t.data;
    bus.req_enable = t.en;
    bus.out_ready  = t.oready;
  endtask

  // Runs one cycle: check grants mid-cycle, update the model, check results after the edge.
  task automatic checkOutput(input vec_t t, input string tag);
    int g;
    res_t r;
    logic [15:0] d;
    #4;
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'(t.exp_ready));
    if (t.rst) begin
      mv = 1'b0; count_m = '0; sb.delete();
      last.data = '0; last.id = '0; last.wrap = 1'b0;
    end else if (t.exp_ready != 4'b0) begin
      g = 0;
      for (int i = 0; i < NUM_REQ; i++) if (t.exp_ready[i]) g = i;
      d = t.data[g*16 +: 16];
      r.data = t.en[g] ? d + 16'd1 : d;
      r.wrap = t.en[g] && (d == 16'hFFFF);
      r.id   = 2'(g);
      if (t.en[g]) count_m = count_m + 16'd1;
      sb.push_back(r);
      mv = 1'b1;
    end else if (mv && t.oready) begin
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) last = sb.pop_front();
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(mv));
    check({tag, "_out_data"},  32'(bus.out_data),  32'(last.data));
    check({tag, "_out_id"},    32'(bus.out_id),    32'(last.id));
    check({tag, "_out_wrap"},  32'(bus.out_wrap),  32'(last.wrap));
    check({tag, "_inc_count"}, 32'(bus.inc_count), 32'(count_m));
  endtask

  initial begin
    vec_t t;
    int ptr_m;
    mv = 1'b0; count_m = '0;
    last.data = '0; last.id = '0; last.wrap = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_enable = '0; bus.out_ready = 1'b0;

    // reset, and a request offered during reset is ignored
    addVec(1, 4'b0000, 64'h0, 4'b0000, 1, 4'b0000);
    addVec(1, 4'b0001, 64'h1234, 4'b0001, 1, 4'b0000);
    // single increment, pass-through of all-ones, then wrap
    addVec(0, 4'b0001, 64'h1234, 4'b0001, 1, 4'b0001);
    addVec(0, 4'b0100, 64'hFFFF_0000_0000, 4'b0000, 1, 4'b0100);
    addVec(0, 4'b0100, 64'hFFFF_0000_0000, 4'b0100, 1, 4'b0100);
    addVec(0, 4'b0000, 64'h0, 4'b0000, 1, 4'b0000);
    addVec(0, 4'b1000, 64'h0300_0000_0000_0000, 4'b1000, 1, 4'b1000);
    // fairness with all requesters valid
    addVec(0, 4'b1111, RR_DATA, 4'b0101, 1, 4'b0001);
    addVec(0, 4'b1111, RR_DATA, 4'b0101, 1, 4'b0010);
    addVec(0, 4'b1111, RR_DATA, 4'b0101, 1, 4'b0100);
    addVec(0, 4'b1111, RR_DATA, 4'b0101, 1, 4'b1000);
    addVec(0, 4'b1111, RR_DATA, 4'b0101, 1, 4'b0001);
    addVec(0, 4'b1111, RR_DATA, 4'b0101, 1, 4'b0010);
    // backpressure for 3 cycles, then grant on the release cycle
    addVec(0, 4'b0110, RR_DATA, 4'b0101, 0, 4'b0000);
    addVec(0, 4'b0110, RR_DATA, 4'b0101, 0, 4'b0000);
    addVec(0, 4'b0110, RR_DATA, 4'b0101, 0, 4'b0000);
    addVec(0, 4'b0110, RR_DATA, 4'b0101, 1, 4'b0100);
    // pointer skip: ptr moves to 1, then 1001 grants 3 then 0
    addVec(0, 4'b0001, RR_DATA, 4'b0101, 1, 4'b0001);
    addVec(0, 4'b1001, RR_DATA, 4'b0101, 1, 4'b1000);
    addVec(0, 4'b1001, RR_DATA, 4'b0101, 1, 4'b0001);
    // mid-operation reset, then first grant goes to 0
    addVec(0, 4'b1111, RR_DATA, 4'b0101, 1, 4'b0010);
    addVec(1, 4'b1111, RR_DATA, 4'b0101, 1, 4'b0000);
    addVec(0, 4'b1111, RR_DATA, 4'b0101, 1, 4'b0001);
    // stall with nothing requested, then drain keeps the data fields
    addVec(0, 4'b0000, RR_DATA, 4'b0101, 0, 4'b0000);
    addVec(0, 4'b0000, RR_DATA, 4'b0101, 1, 4'b0000);

    applyStimulus(vecs[0]);
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("v%0d", i));
    end

    // all requesters valid under random backpressure: grants follow the pointer
    ptr_m = 1;
    for (int c = 0; c < 16; c++) begin
      t.rst = 0; t.valid = 4'b1111; t.data = RR_DATA; t.en = 4'b0101;
      t.oready = 1'($urandom_range(0, 1));
      if (!mv || t.oready) begin
        t.exp_ready = 4'(1 << ptr_m);
        ptr_m = (ptr_m + 1) % NUM_REQ;
      end else begin
        t.exp_ready = 4'b0000;
      end
      applyStimulus(t);
      checkOutput(t, $sformatf("rr%0d", c));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
